reg_index_encoder32: RTL and testbench
======================================

# reg_index_encoder32

Sequential 32-to-5 index encoder: the inverse of the register-file write-enable decoder. It captures a 32-bit request vector (one bit per architectural register), then emits one 5-bit register index per valid/ready handshake, clearing each bit as it is granted, until no requests remain. It is used wherever a multi-register set must be serialised onto a single 5-bit register-address port, such as load/store-multiple sequencing or register-file scrub.

## Interface
- Parameters: none. Width is fixed at 32 requests / 5-bit index.
- `clk  in  1  rising-edge clock`
- `reset  in  1  asynchronous, active-low reset`
- `load  in  1  capture/merge req into pending set this cycle`
- `req  in  32  request vector, bit i = register i`
- `out_ready  in  1  consumer accepts out_idx this cycle`
- `out_valid  out  1  out_idx holds a pending register index`
- `out_idx  out  5  granted register index`
- `busy  out  1  pending set non-empty`
- `done  out  1  one-cycle pulse: last pending index consumed, or empty load`

## Operation
- State: 32-bit `pending` register, 5-bit search pointer `ptr`, FSM {IDLE, BUSY}.
- IDLE: `out_valid`=0, `busy`=0. When `load`=1: `pending` <= `req`. If `req`≠0, go to BUSY. If `req`=0, stay in IDLE and assert `done` for the next cycle.
- BUSY: `out_valid`=1 and `busy`=1. `out_idx` is the index selected from `pending` (see Configuration). It is derived combinationally from registered state only, never from `req` or `out_ready`.
- Handshake: a grant occurs on any edge where `out_valid`=1 and `out_ready`=1. On a grant, the selected bit of `pending` is cleared. `out_idx` must hold stable while `out_valid`=1 and `out_ready`=0, unless a load in the same cycle merges a lower-priority-position bit.
- Load in BUSY: `pending` <= (`pending` with the granted bit cleared) | `req`. A bit set in `req` wins over a simultaneous clear of the same bit.
- Last grant: when the next `pending` value is 0, go to IDLE and pulse `done` for one cycle.
- `out_idx` is 0 whenever `out_valid`=0.
- Reset: asserting `reset` low at any time, including mid-sequence, immediately forces the following values. Pending grants are discarded.
  - `pending`=0, `ptr`=0, state=IDLE
  - `out_valid`=0, `out_idx`=0, `busy`=0, `done`=0

## Timing
- Load-to-first-valid latency: 1 cycle. A `load` sampled at edge k gives `out_valid`=1 in the cycle after edge k.
- Throughput: one index per cycle while `out_ready`=1.
- `done` is registered. It is high for exactly the one cycle after the edge that performed the final grant or the empty load.
- A request vector with N bits set needs exactly N grants. `busy` falls on the same edge at which `done` rises.
- `load` together with a final grant in the same cycle: if the merged `pending` is non-zero, stay in BUSY and do not pulse `done`.

## Configuration
- `REG_ENC_ROUND_ROBIN_EN` defined:
  - Selection is the first set bit of `pending` searching upward from `ptr`, wrapping 31→0.
  - On each grant, `ptr` <= `out_idx`+1 (mod 32).
  - `ptr` persists across loads.
- Not defined:
  - Selection is fixed priority, lowest set index first.
  - `ptr` is not implemented and is held at 0.

## Structure
- Package `reg_enc_pkg`:
  - `localparam` constants `NUM_REGS`=32 and `IDX_W`=5
  - `typedef enum logic {IDLE, BUSY} reg_enc_state_t`
- One sub-module `find_first32`: combinational find-first-set over 32 bits with a 5-bit start index. Outputs the 5-bit index and a `found` flag. Fixed mode ties the start index to 0.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release → all outputs 0, state IDLE.
- Fixed priority: load `req`=0x8000_0011 with `out_ready`=1 → `out_idx` sequence 0, 4, 31 on consecutive cycles, then `done`=1 for one cycle, then `busy`=0.
- Backpressure: load 0x0000_0006, `out_ready`=0 for 3 cycles → `out_idx`=1 held stable. Then `out_ready`=1 → 1, 2, `done`.
- Merge during BUSY: load 0x1, and on the cycle index 0 is granted, load 0x0000_0100 → no `done`. Next `out_idx`=8, then `done`.
- Empty load: `load`=1 with `req`=0 → `out_valid` stays 0, `done`=1 one cycle later.
- Round robin (macro defined): grant index 5 (ptr becomes 6), then load 0x0000_0081 → order 7, 0.
- Mid-sequence reset: load 0xFFFF_FFFF, grant 3 indices, then pulse `reset` low → `pending`=0, `out_valid`=0, no `done`.

Source files
------------

// File: rtl/reg_enc_pkg.sv
// Shared constants and types for the 32-to-5 sequential register index encoder.
package reg_enc_pkg;

    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } reg_enc_state_t;

endpackage

// File: rtl/find_first32.sv
// Combinational find-first-set over 32 bits, searching upward from i_start
// and wrapping 31 -> 0. With i_start = 0 this is plain lowest-index priority.
module find_first32
    import reg_enc_pkg::*;
(
    input  logic [NUM_REGS-1:0] i_vec,
    input  logic [IDX_W-1:0]    i_start,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_found
);

    logic [NUM_REGS-1:0] w_rot;
    logic [IDX_W-1:0]    w_off;

    // Rotate so that bit i_start lands at position 0; 5-bit index add wraps mod 32.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rot[i] = i_vec[IDX_W'(i) + i_start];
        end
    end

    // Lowest set bit of the rotated vector; the downward scan leaves the lowest hit last.
    always_comb begin
        w_off   = '0;
        o_found = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

    assign o_idx = w_off + i_start;

endmodule

// File: rtl/reg_index_encoder32.sv
// Sequential 32-to-5 index encoder: captures a register request vector and
// serialises it as one 5-bit index per valid/ready handshake.
// Optional feature macro: REG_ENC_ROUND_ROBIN_EN (round-robin search pointer).
//
// state | meaning
// IDLE  | pending set empty, out_valid low, waiting for load
// BUSY  | pending set non-empty, out_idx presents the selected index
module reg_index_encoder32
    import reg_enc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [NUM_REGS-1:0] req,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [IDX_W-1:0]    out_idx,
    output logic                busy,
    output logic                done
);

    reg_enc_state_t      r_state;
    logic [NUM_REGS-1:0] r_pending;
    logic [IDX_W-1:0]    r_ptr;
    logic                r_done;

    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_found;
    logic                w_grant;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_next_pending;

    // In fixed-priority builds r_ptr never leaves 0, so the search start is effectively tied low.
    find_first32 u_find (
        .i_vec   (r_pending),
        .i_start (r_ptr),
        .o_idx   (w_sel_idx),
        .o_found (w_found)
    );

    assign busy      = (r_state == BUSY);
    assign out_valid = busy && w_found;
    assign out_idx   = out_valid ? w_sel_idx : '0;
    assign done      = r_done;
    assign w_grant   = out_valid && out_ready;

    // Clear the granted bit first, then OR in the load so a re-requested bit survives.
    always_comb begin
        w_clr_mask = '0;
        if (w_grant) begin
            w_clr_mask = NUM_REGS'(1) << w_sel_idx;
        end
        w_next_pending = r_pending & ~w_clr_mask;
        if (load) begin
            w_next_pending = w_next_pending | req;
        end
    end

    // Pending set, FSM state and the registered done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_state   <= IDLE;
            r_done    <= 1'b0;
        end else begin
            r_pending <= w_next_pending;
            r_state   <= (w_next_pending != '0) ? BUSY : IDLE;
            r_done    <= (w_next_pending == '0) && (busy || load);
        end
    end

    // Search pointer: advances past each granted index, persists across loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else begin
`ifdef REG_ENC_ROUND_ROBIN_EN
            if (w_grant) begin
                r_ptr <= w_sel_idx + IDX_W'(1);
            end
`else
            r_ptr <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_reg_index_encoder32.sv
module tb_reg_index_encoder32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [31:0] req = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    reg_index_encoder32 dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: pending set as a bit array, search from a pointer.
    logic [31:0] m_pend = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_ptr  = 0;

    function automatic int sel(input logic [31:0] p, input int start);
        for (int j = 0; j < 32; j++) begin
            if (p[(start + j) % 32]) return (start + j) % 32;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_ptr  = 0;
    endtask

    task automatic model_edge();
        int  s;
        logic was;
        was = m_busy;
        if (m_busy && out_ready) begin
            s = sel(m_pend, m_ptr);
            m_pend[s] = 1'b0;
`ifdef REG_ENC_ROUND_ROBIN_EN
            m_ptr = (s + 1) % 32;
`endif
        end
        if (load) m_pend = m_pend | req;
        m_done = (m_pend == 0) && (was || load);
        m_busy = (m_pend != 0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [4:0] ei,
                           input logic eb, input logic ed);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " out_idx"},   32'(out_idx),   32'(ei));
        chk({tag, " busy"},      32'(busy),      32'(eb));
        chk({tag, " done"},      32'(done),      32'(ed));
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_busy, m_busy ? 5'(sel(m_pend, m_ptr)) : 5'd0, m_busy, m_done);
    endtask

    typedef struct {
        logic        ld;
        logic [31:0] rq;
        logic        rdy;
        logic        ev;
        logic [4:0]  ei;
        logic        eb;
        logic        ed;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // fixed priority 0,4,31
        tbl[0]  = '{1'b1, 32'h8000_0011, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd4,  1'b1, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd31, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  1'b0, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
        // backpressure
        tbl[5]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd1,  1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd1,  1'b1, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd1,  1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd2,  1'b1, 1'b0};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  1'b0, 1'b1};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
        // merge with the final grant
        tbl[12] = '{1'b1, 32'h0000_0001, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0};
        tbl[13] = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0};
        tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  1'b0, 1'b1};
        // empty load
        tbl[15] = '{1'b1, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 1'b1};
        tbl[16] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 1'b0};
        // re-request of the bit being granted wins
        tbl[17] = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 5'd2,  1'b1, 1'b0};
        tbl[18] = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 5'd2,  1'b1, 1'b0};
        tbl[19] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  1'b0, 1'b1};
        tbl[20] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 1'b0};

        // reset held for two cycles
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("in_reset", 1'b0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_all("after_reset", 1'b0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 21; i++) begin
            load      = tbl[i].ld;
            req       = tbl[i].rq;
            out_ready = tbl[i].rdy;
            step();
            chk_all($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].ei, tbl[i].eb, tbl[i].ed);
        end
        load = 1'b0; req = '0; out_ready = 1'b0;
        step();

`ifdef REG_ENC_ROUND_ROBIN_EN
        // grant index 5 so the pointer moves to 6, then 0x81 must come out as 7, 0
        load = 1'b1; req = 32'h0000_0020; out_ready = 1'b1;
        step();
        chk_all("rr_load5", 1'b1, 5'd5, 1'b1, 1'b0);
        load = 1'b0; req = '0;
        step();
        chk_all("rr_done5", 1'b0, 5'd0, 1'b0, 1'b1);
        load = 1'b1; req = 32'h0000_0081; out_ready = 1'b0;
        step();
        chk_all("rr_first", 1'b1, 5'd7, 1'b1, 1'b0);
        load = 1'b0; req = '0; out_ready = 1'b1;
        step();
        chk_all("rr_second", 1'b1, 5'd0, 1'b1, 1'b0);
        step();
        chk_all("rr_done", 1'b0, 5'd0, 1'b0, 1'b1);
        out_ready = 1'b0;
        step();
`endif

        // mid-sequence reset
        load = 1'b1; req = 32'hFFFF_FFFF; out_ready = 1'b0;
        step();
        chk_model("ms_load");
        load = 1'b0; req = '0; out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            chk_model($sformatf("ms_grant%0d", g));
        end
        #2;
        reset = 1'b0;
        #1;
        chk_all("ms_async_reset", 1'b0, 5'd0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b0;
        step();
        chk_all("ms_after1", 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        chk_all("ms_after2", 1'b0, 5'd0, 1'b0, 1'b0);

        // random stimulus against the model
        for (int c = 0; c < 400; c++) begin
            load = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = 32'h1 << $urandom_range(0, 31);
                2: req = $urandom & $urandom & $urandom;
                default: req = $urandom;
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            chk_model($sformatf("rand[%0d]", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
